// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// Hazard detection and forwarding unit for a five-stage pipeline, with a
// tracker for one multi-cycle unit (MDU) and a saturating stall counter.
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   rs_d, rt_d, rs_e, rt_e          source registers in D and E
//   writereg_e/_m/_w                destination registers in E, M, W
//   memtoreg_e/_m, regwrite_e/_m/_w,
//   branch_d                        stage control bits
//   mdu_op_d, mdu_start_e,
//   mdu_dest_e                      MDU instruction in D / issuing from E
//   perf_clr                        clears stall_count
//   forwarda_d, forwardb_d          D-stage forward from M
//   forwarda_e, forwardb_e          E-stage select: 10 = M, 01 = W, 00 = RF
//   stall_f, stall_d, flush_e       pipeline control
//   mdu_busy, mdu_done, mdu_dest,
//   mdu_err                         MDU tracker status
//   stall_count                     number of stalled cycles (saturating)
//   mdu_state_dbg                   raw MDU FSM state for observation
//
// Handshake: the MDU has no back-pressure. mdu_start_e is a single-cycle
// issue strobe; it is accepted in IDLE or DONE and rejected (flagging
// mdu_err) in BUSY. mdu_done is a one-cycle result-valid pulse.
`timescale 1ns/1ps
module hazard_scoreboard #(
  parameter int AW      = 5,
  parameter int MDU_LAT = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_d,
  input  logic [AW-1:0] rt_d,
  input  logic [AW-1:0] rs_e,
  input  logic [AW-1:0] rt_e,
  input  logic [AW-1:0] writereg_e,
  input  logic [AW-1:0] writereg_m,
  input  logic [AW-1:0] writereg_w,
  input  logic          memtoreg_e,
  input  logic          memtoreg_m,
  input  logic          regwrite_e,
  input  logic          regwrite_m,
  input  logic          regwrite_w,
  input  logic          branch_d,
  input  logic          mdu_op_d,
  input  logic          mdu_start_e,
  input  logic [AW-1:0] mdu_dest_e,
  input  logic          perf_clr,
  output logic          forwarda_d,
  output logic          forwardb_d,
  output logic [1:0]    forwarda_e,
  output logic [1:0]    forwardb_e,
  output logic          stall_f,
  output logic          stall_d,
  output logic          flush_e,
  output logic          mdu_busy,
  output logic          mdu_done,
  output logic [AW-1:0] mdu_dest,
  output logic          mdu_err,
  output logic [CW-1:0] stall_count,
  output logic [1:0]    mdu_state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  localparam logic [7:0] LAT_M1 = 8'(MDU_LAT - 1);

  mdu_state_t    state_q;
  logic [7:0]    cnt_q;
  logic [AW-1:0] dest_q;
  logic          err_q;
  logic          busy_q;
  logic          done_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  logic lwstall;
  logic branchstall;
  logic mdustall;

  // ---------------- forwarding ----------------
  // Register 0 is hard-wired zero, so a match on it never forwards.
  function automatic logic [1:0] fwd_e(input logic [AW-1:0] src);
    if (src != '0 && regwrite_m && writereg_m == src)      return 2'b10;
    else if (src != '0 && regwrite_w && writereg_w == src) return 2'b01;
    else                                                    return 2'b00;
  endfunction

  assign forwarda_e = fwd_e(rs_e);
  assign forwardb_e = fwd_e(rt_e);
  assign forwarda_d = (rs_d != '0) && regwrite_m && (writereg_m == rs_d);
  assign forwardb_d = (rt_d != '0) && regwrite_m && (writereg_m == rt_d);

  // ---------------- stalls ----------------
  assign lwstall = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));

  // Branches resolve in D, so they must wait for an ALU result still in E
  // or a load result still in M.
  assign branchstall = branch_d &&
    ((regwrite_e && (writereg_e != '0) && ((writereg_e == rs_d) || (writereg_e == rt_d))) ||
     (memtoreg_m && (writereg_m != '0) && ((writereg_m == rs_d) || (writereg_m == rt_d))));

  // In DONE the result is already on its way through writeback, so only
  // BUSY holds dependent or competing MDU instructions in D.
  assign mdustall = busy_q &&
    (mdu_op_d || ((dest_q != '0) && ((dest_q == rs_d) || (dest_q == rt_d))));

  assign stall_d = lwstall || branchstall || mdustall;
  assign stall_f = stall_d;
  assign flush_e = stall_d;

  // ---------------- MDU tracker ----------------
  // busy_q/done_q are registered alongside the state so they change only
  // on clock edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dest_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mdu_start_e) begin
            state_q <= S_BUSY;
            dest_q  <= mdu_dest_e;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
          end
        end
        S_BUSY: begin
          if (mdu_start_e) err_q <= 1'b1;
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          if (mdu_start_e) begin
            state_q <= S_BUSY;
            dest_q  <= mdu_dest_e;
            cnt_q   <= LAT_M1;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mdu_busy      = busy_q;
  assign mdu_done      = done_q;
  assign mdu_dest      = dest_q;
  assign mdu_err       = err_q;
  assign mdu_state_dbg = state_q;

  // ---------------- stall counter ----------------
  always_comb begin
    count_d = count_q;
    if (perf_clr)                      count_d = '0;
    else if (stall_d && count_q != '1) count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign stall_count = count_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

  localparam int AW  = 5;
  localparam int LAT = 4;
  localparam int CW  = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // ---------------- DUT signals ----------------
  logic [AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w, mdu_dest_e;
  logic memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w, branch_d;
  logic mdu_op_d, mdu_start_e, perf_clr;

  logic          forwarda_d, forwardb_d, stall_f, stall_d, flush_e;
  logic [1:0]    forwarda_e, forwardb_e;
  logic          mdu_busy, mdu_done, mdu_err;
  logic [AW-1:0] mdu_dest;
  logic [CW-1:0] stall_count;
  logic [1:0]    mdu_state_dbg;

  // second instance with a 2-bit counter to reach saturation quickly
  logic          c_forwarda_d, c_forwardb_d, c_stall_f, c_stall_d, c_flush_e;
  logic [1:0]    c_forwarda_e, c_forwardb_e;
  logic          c_mdu_busy, c_mdu_done, c_mdu_err;
  logic [AW-1:0] c_mdu_dest;
  logic [1:0]    c_stall_count;
  logic [1:0]    c_mdu_state_dbg;

  hazard_scoreboard #(.AW(AW), .MDU_LAT(LAT), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .branch_d(branch_d), .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e),
    .mdu_dest_e(mdu_dest_e), .perf_clr(perf_clr),
    .forwarda_d(forwarda_d), .forwardb_d(forwardb_d),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e),
    .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done), .mdu_dest(mdu_dest),
    .mdu_err(mdu_err), .stall_count(stall_count), .mdu_state_dbg(mdu_state_dbg)
  );

  hazard_scoreboard #(.AW(AW), .MDU_LAT(LAT), .CW(2)) dut_c (
    .clk(clk), .reset(reset),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .writereg_e(writereg_e), .writereg_m(writereg_m), .writereg_w(writereg_w),
    .memtoreg_e(memtoreg_e), .memtoreg_m(memtoreg_m),
    .regwrite_e(regwrite_e), .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .branch_d(branch_d), .mdu_op_d(mdu_op_d), .mdu_start_e(mdu_start_e),
    .mdu_dest_e(mdu_dest_e), .perf_clr(perf_clr),
    .forwarda_d(c_forwarda_d), .forwardb_d(c_forwardb_d),
    .forwarda_e(c_forwarda_e), .forwardb_e(c_forwardb_e),
    .stall_f(c_stall_f), .stall_d(c_stall_d), .flush_e(c_flush_e),
    .mdu_busy(c_mdu_busy), .mdu_done(c_mdu_done), .mdu_dest(c_mdu_dest),
    .mdu_err(c_mdu_err), .stall_count(c_stall_count), .mdu_state_dbg(c_mdu_state_dbg)
  );

  // ---------------- reference model ----------------
  // An MDU operation is described by how many edges have passed since it
  // was accepted: 1..LAT is busy, LAT+1 is the done cycle, 0 means none.
  int            m_age;
  logic [AW-1:0] m_dest;
  bit            m_err;
  longint        m_cnt;
  longint        m_cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic bit m_busy();
    return (m_age >= 1) && (m_age <= LAT);
  endfunction

  function automatic bit m_done();
    return m_age == LAT + 1;
  endfunction

  function automatic bit reads(input logic [AW-1:0] r);
    return (r != 0) && (r == rs_d || r == rt_d);
  endfunction

  function automatic logic [1:0] exp_fwd_e(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (regwrite_m && writereg_m == src) return 2'b10;
    if (regwrite_w && writereg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit exp_stall();
    bit lw, br, md;
    lw = memtoreg_e && reads(rt_e);
    br = branch_d && ((regwrite_e && reads(writereg_e)) || (memtoreg_m && reads(writereg_m)));
    md = m_busy() && (mdu_op_d || reads(m_dest));
    return lw || br || md;
  endfunction

  function automatic longint sat_inc(input longint v, input longint lim);
    return (v + 1 > lim) ? lim : v + 1;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    bit s;
    s = exp_stall();
    check("forwarda_e", 32'(forwarda_e), 32'(exp_fwd_e(rs_e)));
    check("forwardb_e", 32'(forwardb_e), 32'(exp_fwd_e(rt_e)));
    check("forwarda_d", 32'(forwarda_d), 32'(rs_d != 0 && regwrite_m && writereg_m == rs_d));
    check("forwardb_d", 32'(forwardb_d), 32'(rt_d != 0 && regwrite_m && writereg_m == rt_d));
    check("stall_d", 32'(stall_d), 32'(s));
    check("stall_f", 32'(stall_f), 32'(s));
    check("flush_e", 32'(flush_e), 32'(s));
    check("mdu_busy", 32'(mdu_busy), 32'(m_busy()));
    check("mdu_done", 32'(mdu_done), 32'(m_done()));
    check("mdu_dest", 32'(mdu_dest), 32'(m_dest));
    check("mdu_err", 32'(mdu_err), 32'(m_err));
    check("stall_count", 32'(stall_count), 32'(m_cnt));
    check("stall_count_cw2", 32'(c_stall_count), 32'(m_cnt2));
  endtask

  task automatic model_edge();
    bit s;
    s = exp_stall();
    if (reset) begin
      m_age = 0; m_dest = '0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      if (perf_clr) begin
        m_cnt = 0; m_cnt2 = 0;
      end else if (s) begin
        m_cnt  = sat_inc(m_cnt, (64'd1 << CW) - 1);
        m_cnt2 = sat_inc(m_cnt2, 3);
      end
      if (m_busy()) begin
        if (mdu_start_e) m_err = 1;
        m_age++;
      end else if (mdu_start_e) begin
        m_age  = 1;
        m_dest = mdu_dest_e;
      end else begin
        m_age = 0;
      end
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set at the falling edge; this checks them, then crosses
  // one rising edge and returns at the next falling edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    writereg_e = 0; writereg_m = 0; writereg_w = 0; mdu_dest_e = 0;
    memtoreg_e = 0; memtoreg_m = 0; regwrite_e = 0; regwrite_m = 0; regwrite_w = 0;
    branch_d = 0; mdu_op_d = 0; mdu_start_e = 0; perf_clr = 0;
  endtask

  function automatic logic [AW-1:0] rnd_reg();
    return (($urandom_range(0, 9) == 0) ? AW'(9) : AW'($urandom_range(0, 3)));
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    m_age = 0; m_dest = '0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);

    // reset state
    #1;
    check("rst_busy", 32'(mdu_busy), 0);
    check("rst_done", 32'(mdu_done), 0);
    check("rst_dest", 32'(mdu_dest), 0);
    check("rst_err", 32'(mdu_err), 0);
    check("rst_count", 32'(stall_count), 0);
    reset = 1'b0;

    // forwarding: M wins over W; register 0 never forwards
    rs_e = 3; writereg_m = 3; regwrite_m = 1; writereg_w = 3; regwrite_w = 1;
    #1; check("fwd_m_prio", 32'(forwarda_e), 32'(2'b10));
    cycle();
    rs_e = 0;
    #1; check("fwd_zero", 32'(forwarda_e), 32'(2'b00));
    cycle();
    rs_e = 3; regwrite_m = 0;
    #1; check("fwd_w", 32'(forwarda_e), 32'(2'b01));
    cycle();
    idle_inputs();

    // load-use stall and its register-0 exception
    memtoreg_e = 1; rt_e = 7; rs_d = 7;
    #1;
    check("lw_stall_d", 32'(stall_d), 1);
    check("lw_stall_f", 32'(stall_f), 1);
    check("lw_flush_e", 32'(flush_e), 1);
    cycle();
    rt_e = 0; rs_d = 0;
    #1; check("lw_zero", 32'({stall_d, stall_f, flush_e}), 0);
    cycle();
    idle_inputs();

    // MDU timing with a dependent reader in D
    perf_clr = 1; cycle(); perf_clr = 0;
    mdu_start_e = 1; mdu_dest_e = 9; rs_d = 9;
    cycle();
    mdu_start_e = 0;
    for (int i = 1; i <= LAT; i++) begin
      #1;
      check("mdu_busy_win", 32'(mdu_busy), 1);
      check("mdu_dep_stall", 32'(stall_d), 1);
      check("mdu_no_done", 32'(mdu_done), 0);
      cycle();
    end
    #1;
    check("mdu_done_pulse", 32'(mdu_done), 1);
    check("mdu_done_nostall", 32'(stall_d), 0);
    check("mdu_dest9", 32'(mdu_dest), 9);
    // start in the DONE cycle goes straight back to BUSY
    mdu_start_e = 1; mdu_dest_e = 5;
    cycle();
    #1;
    check("b2b_busy", 32'(mdu_busy), 1);
    check("b2b_dest", 32'(mdu_dest), 5);
    // start while BUSY is rejected and flagged
    mdu_dest_e = 6;
    cycle();
    mdu_start_e = 0;
    #1;
    check("busy_err", 32'(mdu_err), 1);
    check("busy_dest_kept", 32'(mdu_dest), 5);
    for (int i = 0; i < LAT + 2; i++) cycle();
    idle_inputs();

    // saturation of the 2-bit counter, then clear with stall active
    perf_clr = 1; cycle(); perf_clr = 0;
    memtoreg_e = 1; rt_e = 4; rt_d = 4;
    for (int i = 1; i <= 5; i++) begin
      cycle();
      #1; check("cw2_count", 32'(c_stall_count), (i > 3) ? 3 : i);
    end
    perf_clr = 1;
    cycle();
    #1; check("cw2_clr", 32'(c_stall_count), 0);
    check("cw16_clr", 32'(stall_count), 0);
    idle_inputs();

    // reset in the second BUSY cycle aborts without a done pulse
    mdu_start_e = 1; mdu_dest_e = 2; rs_d = 2;
    cycle();
    mdu_start_e = 0;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    #1;
    check("rst_busy_abort", 32'(mdu_busy), 0);
    check("rst_count_abort", 32'(stall_count), 0);
    check("rst_err_abort", 32'(mdu_err), 0);
    for (int i = 0; i < LAT + 2; i++) begin
      #1; check("rst_no_done", 32'(mdu_done), 0);
      cycle();
    end

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rs_d = rnd_reg(); rt_d = rnd_reg(); rs_e = rnd_reg(); rt_e = rnd_reg();
      writereg_e = rnd_reg(); writereg_m = rnd_reg(); writereg_w = rnd_reg();
      mdu_dest_e = rnd_reg();
      memtoreg_e = ($urandom_range(0, 3) == 0);
      memtoreg_m = ($urandom_range(0, 3) == 0);
      regwrite_e = $urandom_range(0, 1);
      regwrite_m = $urandom_range(0, 1);
      regwrite_w = $urandom_range(0, 1);
      branch_d   = ($urandom_range(0, 3) == 0);
      mdu_op_d   = ($urandom_range(0, 7) == 0);
      mdu_start_e = ($urandom_range(0, 5) == 0);
      perf_clr   = ($urandom_range(0, 39) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
Parameters (name, default, meaning):
REQ-001 AW, 5, register-address width; register 0 is hard-wired zero and never creates hazards or forwards.
REQ-002 MDU_LAT, 4, multi-cycle unit (MDU) busy cycles per operation; legal range 1..255.
REQ-003 CW, 16, width of the stall performance counter.

Ports (name, direction, width, meaning):
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 rs_d, rt_d, rs_e, rt_e  in  AW each  source registers in the D and E stages.
REQ-007 writereg_e, writereg_m, writereg_w  in  AW each  destination registers in the E, M and W stages.
REQ-008 memtoreg_e, memtoreg_m, regwrite_e, regwrite_m, regwrite_w, branch_d  in  1 each  stage control bits.
REQ-009 mdu_op_d  in  1  MDU instruction in D.
REQ-010 mdu_start_e  in  1  MDU instruction issuing from E this cycle.
REQ-011 mdu_dest_e  in  AW  MDU destination register.
REQ-012 perf_clr  in  1  synchronous clear of stall_count.
REQ-013 forwarda_d, forwardb_d  out  1 each  D-stage forward from M.
REQ-014 forwarda_e, forwardb_e  out  2 each  E-stage forward select: 10 = M, 01 = W, 00 = register file.
REQ-015 stall_f, stall_d, flush_e  out  1 each  pipeline control.
REQ-016 mdu_busy  out  1  MDU state is BUSY.
REQ-017 mdu_done  out  1  one-cycle pulse: MDU result valid.
REQ-018 mdu_dest  out  AW  captured MDU destination register.
REQ-019 mdu_err  out  1  sticky flag: mdu_start_e seen while BUSY.
REQ-020 stall_count  out  CW  count of stalled cycles.

Function
REQ-021 Forwarding is combinational; source 0 never forwards; M has priority over W (E stage); D forwards only from M when regwrite_m=1.
REQ-022 lwstall = memtoreg_e & rt_e!=0 & (rt_e==rs_d | rt_e==rt_d).
REQ-023 branchstall = branch_d & ((regwrite_e & writereg_e!=0 & writereg_e matches rs_d or rt_d) | (memtoreg_m & writereg_m!=0 & writereg_m matches rs_d or rt_d)).
REQ-024 MDU FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-025 IDLE with mdu_start_e=1: go to BUSY, capture mdu_dest_e into mdu_dest, load the counter with MDU_LAT-1.
REQ-026 BUSY: decrement the counter each cycle; when the counter is 0, go to DONE. BUSY therefore lasts exactly MDU_LAT cycles.
REQ-027 DONE lasts one cycle with mdu_done=1. It then goes to BUSY if mdu_start_e=1 (recapturing destination and counter), otherwise to IDLE.
REQ-028 mdu_start_e in BUSY is ignored (destination and counter unchanged) and sets mdu_err; mdu_err clears only on reset.
REQ-029 mdustall = mdu_busy & (mdu_op_d | (mdu_dest!=0 & (mdu_dest==rs_d | mdu_dest==rt_d))).
REQ-030 No dependence stall in DONE; the result enters through the writeback path.
REQ-031 stall_d = lwstall | branchstall | mdustall.
REQ-032 stall_f = stall_d; flush_e = stall_d; all are combinational with no added delays.
REQ-033 stall_count increments by 1 each cycle stall_d=1 and saturates at all-ones.
REQ-034 perf_clr has priority over increment; perf_clr with stall_d=1 yields 0.

Reset
REQ-035 While reset=1: FSM to IDLE; counter, mdu_dest, mdu_err and stall_count cleared to 0. mdu_busy=0 and mdu_done=0 from the next edge.
REQ-036 Reset during BUSY or DONE aborts the operation with no mdu_done pulse. Combinational outputs track inputs throughout reset.

Verification
REQ-037 rs_e=3, writereg_m=3, regwrite_m=1, writereg_w=3, regwrite_w=1 -> forwarda_e=10; same with rs_e=0 -> 00.
REQ-038 memtoreg_e=1, rt_e=7, rs_d=7 -> stall_d=stall_f=flush_e=1. Same with rt_e=0 -> all 0.
REQ-039 MDU_LAT=4, mdu_start_e=1, mdu_dest_e=9 at cycle 0 -> mdu_busy=1 cycles 1-4, mdu_done=1 cycle 5 only. rs_d=9 stalls cycles 1-4, not cycle 5.
REQ-040 mdu_start_e=1 in the DONE cycle -> BUSY next cycle with the new destination, no IDLE gap. mdu_start_e during BUSY -> mdu_err=1, mdu_dest unchanged.
REQ-041 CW=2, stall held 5 cycles -> stall_count 1,2,3,3,3. perf_clr pulse -> 0.
REQ-042 reset asserted in cycle 2 of BUSY -> next cycle mdu_busy=0, stall_count=0, no mdu_done pulse.
